// File: rtl/shared_block_rotate_pipe_pkg.sv
// Shared definitions for the share-preserving lane rotator pipeline.
// Provides rotation-direction encodings, default geometry and the lane-slice
// index helper used to address share s / lane l inside a packed data bus.
package shared_rot_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned DEF_SHARES = 2;
  localparam int unsigned DEF_LANES  = 2;
  localparam int unsigned DEF_LANE_W = 32;

  // Low bit index of share s, lane l in a {share, lane}-packed bus.
  function automatic int unsigned lane_lo(input int unsigned s, input int unsigned l,
                                          input int unsigned lanes, input int unsigned lane_w);
    return (s * lanes + l) * lane_w;
  endfunction

endpackage

// File: rtl/shared_block_rotate_pipe_lane_rotator.sv
// lane_rotator: combinational circular rotation of a single LANE_W-bit lane.
// Ports:
//   x    lane input
//   r    rotation amount, 0..LANE_W-1
//   dir  DIR_LEFT / DIR_RIGHT
//   y_c  rotated lane (combinational)
module lane_rotator
  import shared_rot_pkg::*;
#(
  parameter int unsigned LANE_W = DEF_LANE_W
) (
  input  logic [LANE_W-1:0]         x,
  input  logic [$clog2(LANE_W)-1:0] r,
  input  logic                      dir,
  output logic [LANE_W-1:0]         y_c
);

  localparam int unsigned ROT_W = $clog2(LANE_W);

  logic [ROT_W-1:0]    amt_c;
  logic [2*LANE_W-1:0] dbl_c;

  // Right by r is left by (LANE_W - r) mod LANE_W; the modulo falls out of
  // the ROT_W-bit negate, so r = 0 stays a pass-through.
  always_comb begin
    amt_c = (dir == DIR_RIGHT) ? ROT_W'(ROT_W'(0) - r) : r;
    dbl_c = {x, x} << amt_c;
    y_c   = dbl_c[2*LANE_W-1:LANE_W];
  end

endmodule

// File: rtl/shared_block_rotate_pipe.sv
// shared_block_rotate_pipe: registered, share-preserving lane rotator with a
// valid/ready handshake. Every lane of every share is rotated by the same
// per-transaction amount/direction; shares never combine and each share owns
// its output register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_rot, in_dir      rotation amount and direction, sampled on accept
//   in_data             SHARES*LANES lanes of LANE_W bits, share-major
//   out_valid/out_ready output handshake
//   out_data            rotated data, same packing as in_data
// Build option: SHARED_ROT_SKID_EN adds a skid entry so in_ready comes
// straight from a flop instead of depending on out_ready.
module shared_block_rotate_pipe
  import shared_rot_pkg::*;
#(
  parameter int unsigned SHARES = DEF_SHARES,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned LANE_W = DEF_LANE_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(LANE_W)-1:0]      in_rot,
  input  logic                           in_dir,
  input  logic [SHARES*LANES*LANE_W-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SHARES*LANES*LANE_W-1:0] out_data
);

  localparam int unsigned SHARE_W = LANES * LANE_W;

  logic accept_c;

`ifdef SHARED_ROT_SKID_EN
  logic skid_valid;
  logic main_load_c;
  logic main_from_skid_c;
  logic skid_load_c;

  assign in_ready = ~skid_valid;

  // Route each accept to the main register or, if it is stalled, the skid.
  always_comb begin
    accept_c         = in_valid & ~skid_valid;
    main_load_c      = 1'b0;
    main_from_skid_c = 1'b0;
    skid_load_c      = 1'b0;
    if (skid_valid) begin
      main_from_skid_c = ~out_valid | out_ready;
    end else if (accept_c) begin
      if (~out_valid | out_ready) main_load_c = 1'b1;
      else                        skid_load_c = 1'b1;
    end
  end

  // Occupancy of the main and skid entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_load_c | main_from_skid_c) out_valid <= 1'b1;
      else if (out_ready)                 out_valid <= 1'b0;
      if (skid_load_c)           skid_valid <= 1'b1;
      else if (main_from_skid_c) skid_valid <= 1'b0;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;
  assign accept_c = in_valid & in_ready;

  // Output occupancy: set on accept, cleared on drain without a new accept.
  always_ff @(posedge clk) begin
    if (rst)            out_valid <= 1'b0;
    else if (accept_c)  out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end
`endif

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    logic [SHARE_W-1:0] rot_c;
    logic [SHARE_W-1:0] main_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
      lane_rotator #(.LANE_W(LANE_W)) u_rot (
        .x   (in_data[lane_lo(s, l, LANES, LANE_W) +: LANE_W]),
        .r   (in_rot),
        .dir (in_dir),
        .y_c (rot_c[l*LANE_W +: LANE_W])
      );
    end

`ifdef SHARED_ROT_SKID_EN
    logic [SHARE_W-1:0] skid_q;

    // Per-share main and skid registers; the skid moves forward in order.
    always_ff @(posedge clk) begin
      if (rst) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (main_load_c)           main_q <= rot_c;
        else if (main_from_skid_c) main_q <= skid_q;
        if (skid_load_c) skid_q <= rot_c;
      end
    end
`else
    // Per-share output register isolates each share's rotator glitches.
    always_ff @(posedge clk) begin
      if (rst)           main_q <= '0;
      else if (accept_c) main_q <= rot_c;
    end
`endif

    assign out_data[s*SHARE_W +: SHARE_W] = main_q;
  end

endmodule

// File: tb/tb_shared_block_rotate_pipe.sv
// Self-checking bench for shared_block_rotate_pipe: scoreboard of expected
// outputs pushed on accept and popped on output handshake, plus directed
// checks for reset, latency, stall stability and a 3x4x16 geometry.
module tb_shared_block_rotate_pipe;
  import shared_rot_pkg::*;

  localparam int unsigned DW = 128;
  localparam int unsigned PW = 192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, in_dir, out_valid, out_ready;
  logic [4:0]    in_rot;
  logic [DW-1:0] in_data, out_data;

  logic          p_in_valid, p_in_ready, p_in_dir, p_out_valid, p_out_ready;
  logic [3:0]    p_in_rot;
  logic [PW-1:0] p_in_data, p_out_data;

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] q_exp[$];
  logic [63:0]   q_xor[$];
  logic [DW-1:0] cur_exp;
  logic [63:0]   cur_xor;
  logic          held;
  logic [DW-1:0] held_data;
  bit            bp_mode;
  int            bp_cyc;

  shared_block_rotate_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rot(in_rot), .in_dir(in_dir),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  shared_block_rotate_pipe #(.SHARES(3), .LANES(4), .LANE_W(16)) dut_p (
    .clk(clk), .rst(rst),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_rot(p_in_rot), .in_dir(p_in_dir),
    .in_data(p_in_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit-by-bit reference: bit i of each lane moves to (i +/- r) mod w.
  function automatic logic [255:0] rot_model(input logic [255:0] d, input int r, input bit dir,
                                             input int nl, input int w);
    logic [255:0] y;
    int dst;
    y = '0;
    for (int k = 0; k < nl; k++) begin
      for (int i = 0; i < w; i++) begin
        dst = dir ? (i - r + w) % w : (i + r) % w;
        y[k*w + dst] = d[k*w + i];
      end
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] rand_dw();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Holds in_valid until accepted; returns at posedge+1 after the handshake.
  task automatic send(input logic [DW-1:0] d, input int r, input bit dir, input logic [DW-1:0] exp);
    bit acc = 1'b0;
    in_data  = d;
    in_rot   = 5'(r);
    in_dir   = dir;
    in_valid = 1'b1;
    cur_exp  = exp;
    cur_xor  = 64'(rot_model(256'(d[63:0] ^ d[127:64]), r, dir, 2, 32));
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", 256'(acc), 256'(1));
  endtask

  task automatic send_m(input logic [DW-1:0] d, input int r, input bit dir);
    send(d, r, dir, DW'(rot_model(256'(d), r, dir, 4, 32)));
  endtask

  task automatic drain();
    bit done = 1'b0;
    in_valid  = 1'b0;
    bp_mode   = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = (q_exp.size() == 0) && !out_valid;
    end
    chk("drain_empty", 256'(q_exp.size()), 256'(0));
    @(posedge clk);
    #1;
  endtask

  // Monitor: stall stability, handshake relation, scoreboard pop/push.
  initial begin
    logic [DW-1:0] e;
    logic [63:0]   x;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_valid", 256'(out_valid), 256'(1));
          chk("stall_data", 256'(out_data), 256'(held_data));
        end
        held      = out_valid && !out_ready;
        held_data = out_data;
`ifndef SHARED_ROT_SKID_EN
        chk("in_ready", 256'(in_ready), 256'(!out_valid || out_ready));
`endif
        if (out_valid && out_ready) begin
          chk("spurious_out", 256'(q_exp.size() == 0), 256'(0));
          if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            x = q_xor.pop_front();
            chk("data", 256'(out_data), 256'(e));
            chk("share_xor", 256'(out_data[63:0] ^ out_data[127:64]), 256'(x));
          end
        end
        if (in_valid && in_ready) begin
          q_exp.push_back(cur_exp);
          q_xor.push_back(cur_xor);
        end
      end
    end
  end

  // Back-pressure pattern 1,0,0,1 on out_ready when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = (bp_cyc % 4 == 0) || (bp_cyc % 4 == 3);
        bp_cyc++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    logic [PW-1:0] p_exp;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_rot = '0; in_dir = 1'b0; out_ready = 1'b1;
    p_in_valid = 1'b0; p_in_data = '0; p_in_rot = '0; p_in_dir = 1'b0; p_out_ready = 1'b1;
    bp_mode = 1'b0; bp_cyc = 0; held = 1'b0; cur_exp = '0; cur_xor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_p_valid", 256'(p_out_valid), 256'(0));
    @(posedge clk);
    #1;

    // Fixed 20-bit left rotation and one-cycle latency.
    send({4{32'h12345678}}, 20, DIR_LEFT, {4{32'h67812345}});
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid", 256'(out_valid), 256'(1));
    chk("lat_data", 256'(out_data), 256'({4{32'h67812345}}));
    @(posedge clk);
    #1;

    // Directed right rotations and zero-amount pass-through.
    send({4{32'h12345678}}, 20, DIR_RIGHT, {4{32'h45678123}});
    send({4{32'h00000001}}, 1, DIR_RIGHT, {4{32'h80000000}});
    send({4{32'hDEADBEEF}}, 0, DIR_LEFT, {4{32'hDEADBEEF}});
    send({4{32'hCAFEF00D}}, 0, DIR_RIGHT, {4{32'hCAFEF00D}});

    // Random shares, full amount sweep, both directions.
    for (int r = 0; r < 32; r++) begin
      send_m(rand_dw(), r, DIR_LEFT);
      send_m(rand_dw(), r, DIR_RIGHT);
    end
    drain();

    // Back-to-back under toggling back-pressure.
    bp_cyc  = 0;
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) send_m(rand_dw(), int'($urandom_range(31)), bit'($urandom_range(1)));
    drain();

`ifdef SHARED_ROT_SKID_EN
    // Fill main and skid while stalled; in_ready must not follow out_ready.
    out_ready = 1'b0;
    send_m(rand_dw(), 7, DIR_LEFT);
    send_m(rand_dw(), 9, DIR_RIGHT);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("skid_full_ready", 256'(in_ready), 256'(0));
    out_ready = 1'b1;
    #1;
    chk("skid_ready_indep", 256'(in_ready), 256'(0));
    @(posedge clk);
    #1;
    drain();
`endif

    // Reset while an output is stalled.
    out_ready = 1'b0;
    send_m(rand_dw(), 13, DIR_LEFT);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q_exp.delete();
    q_xor.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 256'(out_valid), 256'(0));
    chk("mid_rst_data", 256'(out_data), 256'(0));
    chk("mid_rst_ready", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send({4{32'h12345678}}, 20, DIR_LEFT, {4{32'h67812345}});
    send_m(rand_dw(), 31, DIR_RIGHT);
    drain();

    // 3 shares x 4 lanes x 16 bits, rotate left by 4.
    p_in_data  = {12{16'hABCD}};
    p_in_rot   = 4'd4;
    p_in_dir   = DIR_LEFT;
    p_in_valid = 1'b1;
    @(negedge clk);
    chk("p_in_ready", 256'(p_in_ready), 256'(1));
    @(posedge clk);
    #1;
    p_in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = p_out_valid;
    end
    chk("p_out_seen", 256'(seen), 256'(1));
    p_exp = {12{16'hBCDA}};
    chk("p_out_data", 256'(p_out_data), 256'(p_exp));
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
